// File: rtl/rv32i_types.sv
// Shared RV32 type definitions.
// Holds the RV32M mult_ops encoding (funct3 order) and the state enum of the
// iterative multiply/divide unit.
package rv32i_types;

    typedef enum logic [2:0] {
        MO_MUL    = 3'd0,
        MO_MULH   = 3'd1,
        MO_MULHSU = 3'd2,
        MO_MULHU  = 3'd3,
        MO_DIV    = 3'd4,
        MO_DIVU   = 3'd5,
        MO_REM    = 3'd6,
        MO_REMU   = 3'd7
    } mult_ops;

    typedef enum logic [1:0] {
        MDU_IDLE  = 2'd0,
        MDU_CALC  = 2'd1,
        MDU_FIXUP = 2'd2,
        MDU_DONE  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one op in flight.
// Ports:
//   clk, rst (async active-high), flush (sync kill)
//   issue_*   : op from the mul reservation station (valid/ready handshake)
//   mul_*     : held result towards the CDB mul port (valid/ready handshake)
//   busy      : unit is not idle
// Datapath: a shared 64-bit {hi,lo} register pair. Multiply keeps the running
// partial product in hi and the shifting multiplier in lo; divide keeps the
// partial remainder in hi and the dividend/quotient in lo. b holds the
// multiplicand or divisor magnitude.
module mul_div_unit
    import rv32i_types::*;
#(
    parameter int ROB_IDX_W  = 5,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [2:0]            issue_multop,
    input  logic [31:0]           issue_rs1_data,
    input  logic [31:0]           issue_rs2_data,
    input  logic [ROB_IDX_W-1:0]  issue_rob_idx,
    input  logic [REG_ADDR_W-1:0] issue_rd_addr,
    output logic                  mul_valid,
    input  logic                  mul_ready,
    output logic [31:0]           mul_data,
    output logic [ROB_IDX_W-1:0]  mul_rob_idx,
    output logic [REG_ADDR_W-1:0] mul_rd_addr,
    output logic                  busy
);

    localparam logic [5:0]  MDU_ITERS = 6'd32;
    localparam logic [5:0]  LAST_ITER = MDU_ITERS - 6'd1;
    localparam logic [31:0] DIV0_QUO  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_QUO   = 32'h8000_0000;
    localparam logic [31:0] OVF_REM   = 32'h0000_0000;

    mdu_state_t            state_q, state_d;
    mult_ops               op_q, op_d;
    logic [5:0]            cnt_q, cnt_d;
    logic [31:0]           hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic                  neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic                  div0_q, div0_d, ovf_q, ovf_d;
    logic [ROB_IDX_W-1:0]  tag_q, tag_d, out_rob_q, out_rob_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d, out_rd_q, out_rd_d;
    logic                  valid_q, valid_d;
    logic [31:0]           data_q, data_d;

    mult_ops     op_in_s;
    logic        a_neg_s, b_neg_s, in_div_s, in_div0_s, in_ovf_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic [32:0] mul_sum_s, div_shift_s;
    logic [33:0] div_diff_s;
    logic [63:0] prod_fix_s;
    logic [31:0] quo_fix_s, rem_fix_s, result_s;

    assign issue_ready = (state_q == MDU_IDLE) && !flush;
    assign busy        = (state_q != MDU_IDLE);
    assign mul_valid   = valid_q;
    assign mul_data    = data_q;
    assign mul_rob_idx = out_rob_q;
    assign mul_rd_addr = out_rd_q;

    // Decode of the incoming op: operand signedness, magnitudes, special cases.
    always_comb begin
        op_in_s   = mult_ops'(issue_multop);
        a_neg_s   = issue_rs1_data[31] && (op_in_s == MO_MUL || op_in_s == MO_MULH ||
                    op_in_s == MO_MULHSU || op_in_s == MO_DIV || op_in_s == MO_REM);
        b_neg_s   = issue_rs2_data[31] && (op_in_s == MO_MUL || op_in_s == MO_MULH ||
                    op_in_s == MO_DIV || op_in_s == MO_REM);
        a_mag_s   = a_neg_s ? (32'd0 - issue_rs1_data) : issue_rs1_data;
        b_mag_s   = b_neg_s ? (32'd0 - issue_rs2_data) : issue_rs2_data;
        in_div_s  = issue_multop[2];
        in_div0_s = in_div_s && (issue_rs2_data == 32'd0);
        in_ovf_s  = (op_in_s == MO_DIV || op_in_s == MO_REM) &&
                    (issue_rs1_data == 32'h8000_0000) && (issue_rs2_data == 32'hFFFF_FFFF);
    end

    // One iteration of shift-add multiply and restoring divide, plus sign fixup.
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
        div_shift_s = {hi_q, lo_q[31]};
        div_diff_s  = {1'b0, div_shift_s} - {2'b00, b_q};
        prod_fix_s  = neg_q ? (64'd0 - {hi_q, lo_q}) : {hi_q, lo_q};
        quo_fix_s   = neg_q ? (32'd0 - lo_q) : lo_q;
        rem_fix_s   = rem_neg_q ? (32'd0 - hi_q) : hi_q;
        // For divide by zero, lo holds the raw dividend loaded at accept.
        if (div0_q) begin
            quo_fix_s = DIV0_QUO;
            rem_fix_s = lo_q;
        end else if (ovf_q) begin
            quo_fix_s = OVF_QUO;
            rem_fix_s = OVF_REM;
        end else begin
            quo_fix_s = quo_fix_s;
            rem_fix_s = rem_fix_s;
        end
        case (op_q)
            MO_MUL:                       result_s = prod_fix_s[31:0];
            MO_MULH, MO_MULHSU, MO_MULHU: result_s = prod_fix_s[63:32];
            MO_DIV, MO_DIVU:              result_s = quo_fix_s;
            MO_REM, MO_REMU:              result_s = rem_fix_s;
            default:                      result_s = 32'd0;
        endcase
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        tag_d     = tag_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        data_d    = data_q;
        out_rob_d = out_rob_q;
        out_rd_d  = out_rd_q;
        if (flush) begin
            state_d = MDU_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (issue_valid && issue_ready) begin
                        op_d      = op_in_s;
                        tag_d     = issue_rob_idx;
                        rd_d      = issue_rd_addr;
                        neg_d     = a_neg_s ^ b_neg_s;
                        rem_neg_d = a_neg_s;
                        div0_d    = in_div0_s;
                        ovf_d     = in_ovf_s;
                        cnt_d     = 6'd0;
                        hi_d      = 32'd0;
                        if (in_div_s) begin
                            lo_d = (in_div0_s || in_ovf_s) ? issue_rs1_data : a_mag_s;
                            b_d  = b_mag_s;
                        end else begin
                            lo_d = b_mag_s;
                            b_d  = a_mag_s;
                        end
                        state_d = (in_div0_s || in_ovf_s) ? MDU_FIXUP : MDU_CALC;
                    end else begin
                        state_d = MDU_IDLE;
                    end
                end
                MDU_CALC: begin
                    if (op_q[2]) begin
                        // Restore when the trial subtraction goes negative.
                        if (div_diff_s[33]) begin
                            hi_d = div_shift_s[31:0];
                            lo_d = {lo_q[30:0], 1'b0};
                        end else begin
                            hi_d = div_diff_s[31:0];
                            lo_d = {lo_q[30:0], 1'b1};
                        end
                    end else begin
                        hi_d = mul_sum_s[32:1];
                        lo_d = {mul_sum_s[0], lo_q[31:1]};
                    end
                    cnt_d   = cnt_q + 6'd1;
                    state_d = (cnt_q == LAST_ITER) ? MDU_FIXUP : MDU_CALC;
                end
                MDU_FIXUP: begin
                    data_d    = result_s;
                    out_rob_d = tag_q;
                    out_rd_d  = rd_q;
                    valid_d   = 1'b1;
                    state_d   = MDU_DONE;
                end
                MDU_DONE: begin
                    if (mul_ready) begin
                        valid_d = 1'b0;
                        state_d = MDU_IDLE;
                    end else begin
                        state_d = MDU_DONE;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    state_d = MDU_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MDU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= MO_MUL;
            cnt_q     <= 6'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            b_q       <= 32'd0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
            tag_q     <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= 32'd0;
            out_rob_q <= '0;
            out_rd_q  <= '0;
        end else begin
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
            tag_q     <= tag_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            out_rob_q <= out_rob_d;
            out_rd_q  <= out_rd_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid, issue_ready, mul_valid, mul_ready, busy;
    logic [2:0]  issue_multop;
    logic [31:0] issue_rs1_data, issue_rs2_data, mul_data;
    logic [4:0]  issue_rob_idx, issue_rd_addr, mul_rob_idx, mul_rd_addr;

    int checks   = 0;
    int failures = 0;

    mul_div_unit #(.ROB_IDX_W(5), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_multop(issue_multop), .issue_rs1_data(issue_rs1_data),
        .issue_rs2_data(issue_rs2_data), .issue_rob_idx(issue_rob_idx),
        .issue_rd_addr(issue_rd_addr), .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_data(mul_data), .mul_rob_idx(mul_rob_idx), .mul_rd_addr(mul_rd_addr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural result computed with plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] pu;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Issue one op, check latency, result, echo, hold under backpressure, retire.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] exp;
        logic [4:0]  tag, rd;
        int          n;
        tag = 5'($urandom);
        rd  = 5'($urandom);
        exp = ref_result(op, a, b);
        @(negedge clk);
        check("issue_ready_idle", 32'(issue_ready), 32'd1);
        issue_valid    = 1'b1;
        issue_multop   = op;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rob_idx  = tag;
        issue_rd_addr  = rd;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (mul_valid) break;
            @(posedge clk);
            n++;
        end
        check($sformatf("latency op%0d", op), 32'(n), 32'(ref_latency(op, a, b)));
        check($sformatf("data op%0d a=%h b=%h", op, a, b), mul_data, exp);
        check("rob_echo", 32'(mul_rob_idx), 32'(tag));
        check("rd_echo", 32'(mul_rd_addr), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(mul_valid), 32'd1);
            check("hold_data", mul_data, exp);
            check("hold_rob", 32'(mul_rob_idx), 32'(tag));
            check("hold_issue_ready", 32'(issue_ready), 32'd0);
        end
        mul_ready = 1'b1;
        @(posedge clk);
        #1 mul_ready = 1'b0;
        @(negedge clk);
        check("retire_issue_ready", 32'(issue_ready), 32'd1);
        check("retire_valid", 32'(mul_valid), 32'd0);
    endtask

    initial begin
        int          vcount;
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; mul_ready = 1'b0;
        issue_multop = 3'd0; issue_rs1_data = 32'd0; issue_rs2_data = 32'd0;
        issue_rob_idx = 5'd0; issue_rd_addr = 5'd0;
        #1;
        check("rst_valid", 32'(mul_valid), 32'd0);
        check("rst_data", mul_data, 32'd0);
        check("rst_rob", 32'(mul_rob_idx), 32'd0);
        check("rst_rd", 32'(mul_rd_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("rst_issue_ready", 32'(issue_ready), 32'd1);

        // Directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd7, 32'd2, 0);
        run_op(3'd7, 32'd7, 32'd2, 0);
        run_op(3'd4, 32'd5, 32'd0, 0);
        run_op(3'd7, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'h1234_5678, 32'h0000_0011, 10);

        // Randomized ops with occasional special operands
        for (int k = 0; k < 24; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                default: b = b;
            endcase
            run_op(op, a, b, int'($urandom_range(0, 3)));
        end

        // Flush in cycle 10 of CALC
        @(negedge clk);
        issue_valid = 1'b1; issue_multop = 3'd0;
        issue_rs1_data = 32'd9; issue_rs2_data = 32'd9;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_issue_ready", 32'(issue_ready), 32'd1);
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (mul_valid) vcount++;
        end
        check("flush_no_valid", 32'(vcount), 32'd0);
        run_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1);

        // Flush together with issue: not accepted
        @(negedge clk);
        issue_valid = 1'b1; flush = 1'b1; issue_multop = 3'd5;
        issue_rs1_data = 32'd100; issue_rs2_data = 32'd3;
        #1 check("flush_issue_ready_low", 32'(issue_ready), 32'd0);
        @(posedge clk);
        #1 begin issue_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_issue_not_taken", 32'(busy), 32'd0);

        // Async reset mid-CALC; mul_data still holds the last nonzero result
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        @(negedge clk);
        issue_valid = 1'b1; issue_multop = 3'd4;
        issue_rs1_data = 32'd1000; issue_rs2_data = 32'd7;
        @(posedge clk);
        #1 issue_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(mul_valid), 32'd0);
        check("arst_data", mul_data, 32'd0);
        check("arst_rob", 32'(mul_rob_idx), 32'd0);
        check("arst_rd", 32'(mul_rd_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("arst_issue_ready", 32'(issue_ready), 32'd1);
        run_op(3'd6, 32'hFFFF_FC18, 32'd7, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
